// File: rtl/check_state_engine_pkg.sv
// Shared definitions for the check-state engine: FSM encoding, default geometry and play modes.
package check_state_engine_pkg;

  localparam int unsigned DEF_SYM_W      = 2;
  localparam int unsigned DEF_MAX_ROUNDS = 16;
  localparam int unsigned DEF_LIVES      = 3;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_LIVES  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_RESULT  = 2'd2
  } state_e;

endpackage

// File: rtl/check_state_engine_if.sv
// Request/result bundle between the game FSM (master) and the check-state engine (slave).
interface check_state_engine_if #(
  parameter int unsigned SYM_W      = 2,
  parameter int unsigned MAX_ROUNDS = 16,
  parameter int unsigned LIVES      = 3
);
  localparam int unsigned RND_W = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int unsigned LV_W  = $clog2(LIVES + 1);
  localparam int unsigned SEQ_W = SYM_W * MAX_ROUNDS;

  logic             en_check;
  logic             mode_lives;
  logic [SEQ_W-1:0] seq_in_check;
  logic [SEQ_W-1:0] seq_mem;
  logic [RND_W-1:0] round_ctr_in;
  logic [RND_W-1:0] round_ctr_out;
  logic             complete_check;
  logic             fail_check;
  logic             game_complete;
  logic             game_over;
  logic [LV_W-1:0]  lives_out;
  logic [RND_W-1:0] mismatch_idx;
  logic             busy;

  modport master (
    output en_check, mode_lives, seq_in_check, seq_mem, round_ctr_in,
    input  round_ctr_out, complete_check, fail_check, game_complete, game_over,
           lives_out, mismatch_idx, busy
  );

  modport slave (
    input  en_check, mode_lives, seq_in_check, seq_mem, round_ctr_in,
    output round_ctr_out, complete_check, fail_check, game_complete, game_over,
           lives_out, mismatch_idx, busy
  );
endinterface

// File: rtl/check_state_engine_seq_symbol_sel.sv
// Combinational index -> symbol mux over a packed symbol sequence.
module check_state_engine_seq_symbol_sel #(
  parameter  int unsigned SYM_W      = 2,
  parameter  int unsigned MAX_ROUNDS = 16,
  localparam int unsigned RND_W      = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1
) (
  input  logic [SYM_W*MAX_ROUNDS-1:0] seq,
  input  logic [RND_W-1:0]            idx,
  output logic [SYM_W-1:0]            sym_c
);

  always_comb begin
    sym_c = '0;
    for (int i = 0; i < int'(MAX_ROUNDS); i++) begin
      if (idx == RND_W'(i)) sym_c = seq[i*SYM_W +: SYM_W];
    end
  end

endmodule

// File: rtl/check_state_engine.sv
// Check state of the memory game: walks symbols 0..r of the player and stored sequences,
// stops at the first mismatch and reports pass/fail with round, lives and game-end tracking.
module check_state_engine
  import check_state_engine_pkg::*;
#(
  parameter int unsigned SYM_W      = DEF_SYM_W,
  parameter int unsigned MAX_ROUNDS = DEF_MAX_ROUNDS,
  parameter int unsigned LIVES      = DEF_LIVES
) (
  input  logic                  clk,
  input  logic                  rst_check,
  check_state_engine_if.slave   bus
);

  localparam int unsigned RND_W = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;
  localparam int unsigned LV_W  = $clog2(LIVES + 1);
  localparam int unsigned SEQ_W = SYM_W * MAX_ROUNDS;

  state_e           state_q, state_d;
  logic             start_c;
  logic [SEQ_W-1:0] seq_in_q, seq_mem_q;
  logic [RND_W-1:0] rnd_q, idx_q, fail_idx_q;
  logic             mode_q, pass_q;
  logic [SYM_W-1:0] sym_in_c, sym_mem_c;
  logic             mismatch_c, last_c;

  logic [RND_W-1:0] round_q, mismatch_q;
  logic [LV_W-1:0]  lives_q;
  logic             complete_q, fail_q, game_complete_q, game_over_q, busy_q;

  check_state_engine_seq_symbol_sel #(.SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS)) u_sel_in (
    .seq   (seq_in_q),
    .idx   (idx_q),
    .sym_c (sym_in_c)
  );

  check_state_engine_seq_symbol_sel #(.SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS)) u_sel_mem (
    .seq   (seq_mem_q),
    .idx   (idx_q),
    .sym_c (sym_mem_c)
  );

  assign mismatch_c = (sym_in_c != sym_mem_c);
  assign last_c     = (idx_q == rnd_q);

  always_ff @(posedge clk) begin
    if (rst_check) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Start is refused once the game has ended (won or out of lives) until reset.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en_check && !game_complete_q && !game_over_q) begin
          start_c = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (mismatch_c || last_c) state_d = ST_RESULT;
      end
      ST_RESULT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Latched operands and the compare walk.
  always_ff @(posedge clk) begin
    if (rst_check) begin
      seq_in_q   <= '0;
      seq_mem_q  <= '0;
      rnd_q      <= '0;
      idx_q      <= '0;
      fail_idx_q <= '0;
      mode_q     <= MODE_STRICT;
      pass_q     <= 1'b0;
    end else if (start_c) begin
      seq_in_q  <= bus.seq_in_check;
      seq_mem_q <= bus.seq_mem;
      rnd_q     <= bus.round_ctr_in;
      mode_q    <= bus.mode_lives;
      idx_q     <= '0;
    end else if (state_q == ST_COMPARE) begin
      if (mismatch_c) begin
        pass_q     <= 1'b0;
        fail_idx_q <= idx_q;
      end else if (last_c) begin
        pass_q <= 1'b1;
      end else begin
        idx_q <= idx_q + RND_W'(1);
      end
    end
  end

  // Outcome registers: pulses and round/lives updates happen only on leaving RESULT.
  always_ff @(posedge clk) begin
    if (rst_check) begin
      round_q         <= '0;
      mismatch_q      <= '0;
      lives_q         <= LV_W'(LIVES);
      complete_q      <= 1'b0;
      fail_q          <= 1'b0;
      game_complete_q <= 1'b0;
      game_over_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      fail_q     <= 1'b0;
      busy_q     <= (state_d != ST_IDLE);
      if (state_q == ST_RESULT) begin
        if (pass_q) begin
          complete_q <= 1'b1;
          if (rnd_q == RND_W'(MAX_ROUNDS - 1)) begin
            round_q         <= '0;
            game_complete_q <= 1'b1;
          end else begin
            round_q <= rnd_q + RND_W'(1);
          end
        end else begin
          fail_q     <= 1'b1;
          mismatch_q <= fail_idx_q;
          if (mode_q == MODE_LIVES) begin
            if (lives_q == LV_W'(1)) begin
              round_q     <= '0;
              lives_q     <= LV_W'(LIVES);
              game_over_q <= 1'b1;
            end else begin
              round_q <= rnd_q;
              lives_q <= lives_q - LV_W'(1);
            end
          end else begin
            round_q <= '0;
          end
        end
      end
    end
  end

  assign bus.round_ctr_out  = round_q;
  assign bus.complete_check = complete_q;
  assign bus.fail_check     = fail_q;
  assign bus.game_complete  = game_complete_q;
  assign bus.game_over      = game_over_q;
  assign bus.lives_out      = lives_q;
  assign bus.mismatch_idx   = mismatch_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_check_state_engine.sv
// Scoreboard bench for check_state_engine: directed runs push expected results, a negedge monitor checks pulses.
module tb_check_state_engine;
  import check_state_engine_pkg::*;

  localparam int unsigned SYM_W      = 2;
  localparam int unsigned MAX_ROUNDS = 16;
  localparam int unsigned LIVES      = 3;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned LV_W       = 2;
  localparam int unsigned SEQ_W      = 32;

  typedef struct {
    logic             pass;
    logic [RND_W-1:0] round;
    logic [LV_W-1:0]  lives;
    logic [RND_W-1:0] idx;
    logic             gc;
    logic             go;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_check;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  check_state_engine_if #(.SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS), .LIVES(LIVES)) bus ();

  check_state_engine #(.SYM_W(SYM_W), .MAX_ROUNDS(MAX_ROUNDS), .LIVES(LIVES)) dut (
    .clk       (clk),
    .rst_check (rst_check),
    .bus       (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_check && (bus.complete_check || bus.fail_check)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.complete_check, bus.fail_check}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({bus.complete_check, bus.fail_check}), 32'({e.pass, ~e.pass}));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("round_ctr_out", 32'(bus.round_ctr_out), 32'(e.round));
        check("lives_out", 32'(bus.lives_out), 32'(e.lives));
        check("game_complete", 32'(bus.game_complete), 32'(e.gc));
        check("game_over", 32'(bus.game_over), 32'(e.go));
        if (!e.pass) check("mismatch_idx", 32'(bus.mismatch_idx), 32'(e.idx));
      end
    end
  end

  // Issue one start pulse; expected result (if any) is queued with its due cycle.
  task automatic start(input logic [RND_W-1:0] r, input logic [SEQ_W-1:0] si,
                       input logic [SEQ_W-1:0] sm, input logic mode,
                       input bit expect_result, input exp_t e, input int k);
    exp_t x;
    bus.en_check     = 1'b1;
    bus.round_ctr_in = r;
    bus.seq_in_check = si;
    bus.seq_mem      = sm;
    bus.mode_lives   = mode;
    x     = e;
    x.cyc = cyc + 1 + k + 2;
    if (expect_result) sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    bus.en_check     = 1'b0;
    bus.seq_in_check = ~si;
    bus.seq_mem      = ~sm;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles", bus.busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_check = 1'b1;
    @(negedge clk);
    rst_check = 1'b0;
  endtask

  function automatic exp_t mk(input logic pass, input int round, input int lives,
                              input int idx, input logic gc, input logic go);
    exp_t e;
    e.pass  = pass;
    e.round = RND_W'(round);
    e.lives = LV_W'(lives);
    e.idx   = RND_W'(idx);
    e.gc    = gc;
    e.go    = go;
    e.cyc   = 0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d scoreboard entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SEQ_W-1:0] mem_a;
    mem_a = 32'h0ABCDEF0;
    bus.en_check     = 1'b0;
    bus.mode_lives   = MODE_STRICT;
    bus.seq_in_check = '0;
    bus.seq_mem      = '0;
    bus.round_ctr_in = '0;
    rst_check        = 1'b1;
    repeat (2) @(negedge clk);
    rst_check = 1'b0;

    check("rst_round", 32'(bus.round_ctr_out), 32'd0);
    check("rst_lives", 32'(bus.lives_out), 32'd3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_flags", 32'({bus.game_complete, bus.game_over}), 32'd0);
    check("rst_pulses", 32'({bus.complete_check, bus.fail_check}), 32'd0);
    check("rst_mismatch_idx", 32'(bus.mismatch_idx), 32'd0);

    // r=0 equal, strict: pass, next round 1
    start(4'd0, mem_a, mem_a, MODE_STRICT, 1'b1, mk(1'b1, 1, 3, 0, 1'b0, 1'b0), 0);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_idle();

    // symbol 0 differs: fail at index 0
    start(4'd1, 32'hDEADBEEF, mem_a, MODE_STRICT, 1'b1, mk(1'b0, 0, 3, 0, 1'b0, 1'b0), 0);
    wait_idle();

    // only symbol 9 differs, r=2: pass
    start(4'd2, 32'h0AB0DEF0, mem_a, MODE_STRICT, 1'b1, mk(1'b1, 3, 3, 0, 1'b0, 1'b0), 2);
    wait_idle();

    // lives mode, symbol 3 differs three times
    start(4'd5, 32'h0ABCDE30, mem_a, MODE_LIVES, 1'b1, mk(1'b0, 5, 2, 3, 1'b0, 1'b0), 3);
    wait_idle();
    start(4'd5, 32'h0ABCDE30, mem_a, MODE_LIVES, 1'b1, mk(1'b0, 5, 1, 3, 1'b0, 1'b0), 3);
    wait_idle();
    start(4'd5, 32'h0ABCDE30, mem_a, MODE_LIVES, 1'b1, mk(1'b0, 0, 3, 3, 1'b0, 1'b1), 3);
    wait_idle();
    start(4'd1, mem_a, mem_a, MODE_STRICT, 1'b0, mk(1'b1, 0, 0, 0, 1'b0, 1'b0), 0);
    check("game_over_blocks_start", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);

    // last round: game_complete, later start ignored
    do_reset();
    start(4'd15, mem_a, mem_a, MODE_STRICT, 1'b1, mk(1'b1, 0, 3, 0, 1'b1, 1'b0), 15);
    wait_idle();
    start(4'd3, mem_a, mem_a, MODE_STRICT, 1'b0, mk(1'b1, 0, 0, 0, 1'b0, 1'b0), 0);
    check("complete_blocks_start", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    check("complete_sticky", 32'(bus.game_complete), 32'd1);

    // en_check re-asserted while busy: exactly one result
    do_reset();
    start(4'd7, mem_a, mem_a, MODE_STRICT, 1'b1, mk(1'b1, 8, 3, 0, 1'b0, 1'b0), 7);
    bus.en_check = 1'b1;
    repeat (4) @(negedge clk);
    bus.en_check = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);

    // reset during compare aborts with no pulse
    start(4'd7, mem_a, mem_a, MODE_LIVES, 1'b0, mk(1'b1, 0, 0, 0, 1'b0, 1'b0), 7);
    repeat (3) @(negedge clk);
    do_reset();
    check("abort_round", 32'(bus.round_ctr_out), 32'd0);
    check("abort_lives", 32'(bus.lives_out), 32'd3);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_flags", 32'({bus.game_complete, bus.game_over, bus.mismatch_idx}), 32'd0);
    repeat (15) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
